// File: rtl/temp_monitor_pkg.sv
// Shared configuration, FSM encoding and display helpers for the temperature monitor.
package temp_monitor_pkg;

    localparam int S_NR       = 8;
    localparam int TEMP_WIDTH = 8;
    localparam int T_MIN      = 19;
    localparam int T_MAX      = 26;

    localparam int LED_W = T_MAX - T_MIN + 1;
    localparam int DIV_W = 2 * TEMP_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } state_t;

    localparam logic [LED_W-1:0] LED_ALL = '1;

    // Thermometer bar: bit 0 always lit for any average, one more bit per degree above T_MIN.
    function automatic logic [LED_W-1:0] led_encode(input logic [DIV_W-1:0] a);
        logic [LED_W-1:0] bar;
        if (a <= DIV_W'(T_MIN)) begin
            bar = LED_W'(1);
        end else if (a >= DIV_W'(T_MAX)) begin
            bar = LED_ALL;
        end else begin
            // Each degree short of T_MAX drops one bar segment from the top.
            bar = LED_ALL >> (DIV_W'(T_MAX) - a);
        end
        return bar;
    endfunction

    // Endpoints of the comfort window count as in range.
    function automatic logic out_of_range(input logic [DIV_W-1:0] a);
        return (a < DIV_W'(T_MIN)) || (a > DIV_W'(T_MAX));
    endfunction

endpackage

// File: rtl/seq_divider.sv
// DIV_W-bit restoring divider, one quotient bit per clock, MSB first.
// A zero divisor yields an all-ones quotient and a remainder equal to the dividend.
module seq_divider
    import temp_monitor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [DIV_W-1:0] n,
    input  logic [DIV_W-1:0] d,
    output logic             busy,
    output logic             valid,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r
);

    localparam int CNT_W = $clog2(DIV_W);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DIV_W-1:0] den_q;
    logic [CNT_W-1:0] step_q;
    logic             busy_q;
    logic             valid_q;

    logic [DIV_W:0]   rem_shift;
    logic             fits;
    logic [DIV_W-1:0] rem_next;

    // One restoring step: shift in the next dividend bit and subtract when the divisor fits.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        rem_shift = {rem_q, quo_q[DIV_W-1]};
        fits      = rem_shift >= {1'b0, den_q};
        // The true difference is always below den_q, so the low DIV_W bits carry it exactly;
        // with a zero divisor the shifted-out top bit is lost and the dividend accumulates here.
        rem_next  = fits ? (rem_shift[DIV_W-1:0] - den_q) : rem_shift[DIV_W-1:0];
    end

    // Load operands on go, then iterate DIV_W steps and flag the result for one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (busy_q) begin
                rem_q  <= rem_next;
                quo_q  <= {quo_q[DIV_W-2:0], fits};
                step_q <= step_q + 1'b1;
                if (step_q == CNT_W'(DIV_W - 1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end else if (go) begin
                rem_q  <= '0;
                quo_q  <= n;
                den_q  <= d;
                step_q <= '0;
                busy_q <= 1'b1;
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign q     = quo_q;
    assign r     = rem_q;

endmodule

// File: rtl/temp_monitor_system.sv
// Multi-sensor temperature monitor: sums and counts the enabled readings, averages them
// with the sequential divider and drives a thermometer LED bar plus an out-of-range alert.
module temp_monitor_system
    import temp_monitor_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [S_NR*TEMP_WIDTH-1:0]   temp_value,
    input  logic [S_NR-1:0]              temp_enable,
    output logic                         busy,
    output logic                         done,
    output logic [DIV_W-1:0]             avg_q,
    output logic [DIV_W-1:0]             avg_r,
    output logic [LED_W-1:0]             led_output,
    output logic                         alert
);

    // Configuration guards: the sensor count must fit the reading width and the sum the divider.
    if (S_NR > 2 ** TEMP_WIDTH) begin : g_bad_sensor_count
        $error("temp_monitor_system: S_NR exceeds 2**TEMP_WIDTH");
    end
    if (S_NR * (2 ** TEMP_WIDTH - 1) >= 2 ** DIV_W) begin : g_bad_sum_width
        $error("temp_monitor_system: sensor sum overflows DIV_W");
    end

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             d_zero;

    logic [DIV_W-1:0] sum;
    logic [DIV_W-1:0] pop;

    logic             div_busy;
    logic             div_valid;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_r;

    // A new request is taken whenever no division is running, including the done cycle.
    assign accept = start && (state != DIVIDE);

    // Front end: sum and count of the enabled sensors.
    always_comb begin
        sum = '0;
        pop = '0;
        for (int k = 0; k < S_NR; k++) begin
            if (temp_enable[k]) begin
                sum = sum + DIV_W'(temp_value[k*TEMP_WIDTH +: TEMP_WIDTH]);
                pop = pop + DIV_W'(1);
            end
        end
    end

    seq_divider u_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (accept),
        .n     (sum),
        .d     (pop),
        .busy  (div_busy),
        .valid (div_valid),
        .q     (div_q),
        .r     (div_r)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DIVIDE;
            DIVIDE: begin
                if (div_valid) begin
                    state_next = FINISH;
                end else if (!div_busy) begin
                    // Divider idle without a result cannot occur in normal operation; drop back.
                    state_next = IDLE;
                end
            end
            FINISH:  state_next = accept ? DIVIDE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the state.
    always_comb begin
        busy = (state == DIVIDE);
        done = (state == FINISH);
    end

    // Remember whether the accepted request had no sensor enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_zero <= 1'b0;
        end else if (accept) begin
            d_zero <= (pop == '0);
        end
    end

    // Result registers: update exactly once per operation, hold until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avg_q      <= '0;
            avg_r      <= '0;
            led_output <= '0;
            alert      <= 1'b0;
        end else if (state == DIVIDE && div_valid) begin
            if (d_zero) begin
                avg_q      <= '0;
                avg_r      <= '0;
                led_output <= '0;
                alert      <= 1'b1;
            end else begin
                avg_q      <= div_q;
                avg_r      <= div_r;
                led_output <= led_encode(div_q);
                alert      <= out_of_range(div_q);
            end
        end
    end

endmodule

// File: tb/tb_temp_monitor_system.sv
// Self-checking bench for temp_monitor_system: directed test-plan vectors, randomized
// operations against an arithmetic reference model, back-to-back, start-while-busy and reset abort.
module tb_temp_monitor_system;
    import temp_monitor_pkg::*;

    localparam int VW      = S_NR * TEMP_WIDTH;
    localparam int LATENCY = DIV_W + 1;
    localparam int MAX_WAIT = 40;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [VW-1:0]        temp_value;
    logic [S_NR-1:0]      temp_enable;
    logic                 busy;
    logic                 done;
    logic [DIV_W-1:0]     avg_q;
    logic [DIV_W-1:0]     avg_r;
    logic [LED_W-1:0]     led_output;
    logic                 alert;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temp_monitor_system dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .temp_value  (temp_value),
        .temp_enable (temp_enable),
        .busy        (busy),
        .done        (done),
        .avg_q       (avg_q),
        .avg_r       (avg_r),
        .led_output  (led_output),
        .alert       (alert)
    );

    // Reference: plain arithmetic mean of the enabled sensors and a bar lit up to the average.
    task automatic model(input logic [VW-1:0] v, input logic [S_NR-1:0] en,
                         output logic [DIV_W-1:0] q, output logic [DIV_W-1:0] r,
                         output logic [LED_W-1:0] led, output logic al);
        int sum = 0;
        int cnt = 0;
        for (int k = 0; k < S_NR; k++) begin
            if (en[k]) begin
                sum += int'(v[k*TEMP_WIDTH +: TEMP_WIDTH]);
                cnt++;
            end
        end
        if (cnt == 0) begin
            q = '0; r = '0; led = '0; al = 1'b1;
        end else begin
            q  = DIV_W'(sum / cnt);
            r  = DIV_W'(sum % cnt);
            al = (sum / cnt < T_MIN) || (sum / cnt > T_MAX);
            for (int i = 0; i < LED_W; i++)
                led[i] = (i == 0) || (sum / cnt >= T_MIN + i);
        end
    endtask

    function automatic logic [VW-1:0] random_readings();
        logic [VW-1:0] v;
        for (int k = 0; k < S_NR; k++) begin
            if ($urandom_range(1, 0) == 1)
                v[k*TEMP_WIDTH +: TEMP_WIDTH] = TEMP_WIDTH'($urandom_range(30, 15));
            else
                v[k*TEMP_WIDTH +: TEMP_WIDTH] = TEMP_WIDTH'($urandom);
        end
        return v;
    endfunction

    // Called at a negedge: request one operation, scramble inputs while busy, wait for done.
    // Returns at the negedge where done is high (or after the wait budget expires).
    task automatic run_op(input logic [VW-1:0] v, input logic [S_NR-1:0] en, output int lat);
        temp_value  = v;
        temp_enable = en;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        temp_value  = {$urandom, $urandom};
        temp_enable = S_NR'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        temp_value  = '0;
        temp_enable = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, avg_q, avg_r, led_output, alert} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {busy, done, avg_q, avg_r, led_output, alert});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [VW-1:0]    vals  [8];
        logic [S_NR-1:0]  ens   [8];
        logic [DIV_W-1:0] e_q   [8] = '{22, 22, 10, 19, 26, 30, 0, 255};
        logic [DIV_W-1:0] e_r   [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [LED_W-1:0] e_led [8] = '{8'h0F, 8'h0F, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        logic             e_al  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat;
        vals[0] = {S_NR{8'd22}};                  ens[0] = 8'hFF;
        vals[1] = {{6{8'd99}}, 8'd25, 8'd20};     ens[1] = 8'h03;
        vals[2] = {{7{8'd200}}, 8'd10};           ens[2] = 8'h01;
        vals[3] = {{7{8'd200}}, 8'd19};           ens[3] = 8'h01;
        vals[4] = {{7{8'd200}}, 8'd26};           ens[4] = 8'h01;
        vals[5] = {{7{8'd200}}, 8'd30};           ens[5] = 8'h01;
        vals[6] = {S_NR{8'd50}};                  ens[6] = 8'h00;
        vals[7] = {S_NR{8'd255}};                 ens[7] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            run_op(vals[i], ens[i], lat);
            checks++;
            if (lat !== LATENCY) begin
                failures++;
                $display("FAIL directed[%0d] latency got=%0d exp=%0d", i, lat, LATENCY);
            end
            checks++;
            if (avg_q !== e_q[i] || avg_r !== e_r[i]) begin
                failures++;
                $display("FAIL directed[%0d] avg got=%0d r%0d exp=%0d r%0d", i, avg_q, avg_r, e_q[i], e_r[i]);
            end
            checks++;
            if (led_output !== e_led[i] || alert !== e_al[i]) begin
                failures++;
                $display("FAIL directed[%0d] led/alert got=%h/%b exp=%h/%b", i, led_output, alert, e_led[i], e_al[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL directed[%0d] done_pulse got done=%b busy=%b exp 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0]    v;
        logic [S_NR-1:0]  en;
        logic [DIV_W-1:0] q, r;
        logic [LED_W-1:0] led;
        logic             al;
        int lat;
        for (int t = 0; t < 40; t++) begin
            v  = random_readings();
            en = (t % 10 == 0) ? '0 : S_NR'($urandom);
            model(v, en, q, r, led, al);
            run_op(v, en, lat);
            checks++;
            if (lat !== LATENCY || avg_q !== q || avg_r !== r || led_output !== led || alert !== al) begin
                failures++;
                $display("FAIL random[%0d] got lat=%0d q=%0d r=%0d led=%h al=%b exp lat=%0d q=%0d r=%0d led=%h al=%b",
                         t, lat, avg_q, avg_r, led_output, alert, LATENCY, q, r, led, al);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0]    v;
        logic [S_NR-1:0]  en;
        logic [DIV_W-1:0] q, r;
        logic [LED_W-1:0] led;
        logic             al;
        int lat;
        for (int t = 0; t < 4; t++) begin
            v  = random_readings();
            en = S_NR'($urandom) | 8'h01;
            model(v, en, q, r, led, al);
            // No idle cycle: the next request goes in on the cycle done is high.
            run_op(v, en, lat);
            checks++;
            if (lat !== LATENCY || avg_q !== q || avg_r !== r || led_output !== led || alert !== al) begin
                failures++;
                $display("FAIL back_to_back[%0d] got lat=%0d q=%0d r=%0d led=%h al=%b exp lat=%0d q=%0d r=%0d led=%h al=%b",
                         t, lat, avg_q, avg_r, led_output, alert, LATENCY, q, r, led, al);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        logic [VW-1:0]    v;
        logic [DIV_W-1:0] q, r, got_q;
        logic [LED_W-1:0] led;
        logic             al;
        int n_done = 0;
        int first  = -1;
        v = {8'd30, 8'd18, 8'd24, 8'd22, 8'd21, 8'd23, 8'd20, 8'd25};
        model(v, 8'hFF, q, r, led, al);
        got_q       = '0;
        temp_value  = v;
        temp_enable = 8'hFF;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b exp=1", busy);
        end
        for (int i = 1; i <= MAX_WAIT; i++) begin
            if (i == 5) begin
                temp_value  = {S_NR{8'd3}};
                temp_enable = 8'h01;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) begin
                    first = i;
                    got_q = avg_q;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 1 || first !== LATENCY) begin
            failures++;
            $display("FAIL start_while_busy done_count got=%0d at=%0d exp=1 at=%0d", n_done, first, LATENCY);
        end
        checks++;
        if (got_q !== q) begin
            failures++;
            $display("FAIL start_while_busy result got=%0d exp=%0d", got_q, q);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [DIV_W-1:0] q, r;
        logic [LED_W-1:0] led;
        logic             al;
        int n_done = 0;
        int lat;
        temp_value  = {S_NR{8'd21}};
        temp_enable = 8'hFF;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, avg_q, avg_r, led_output, alert} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op outputs got=%h exp=0", {busy, done, avg_q, avg_r, led_output, alert});
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL reset_mid_op stray_done got=%0d exp=0", n_done);
        end
        model({S_NR{8'd24}}, 8'h0F, q, r, led, al);
        run_op({S_NR{8'd24}}, 8'h0F, lat);
        checks++;
        if (lat !== LATENCY || avg_q !== q || led_output !== led || alert !== al) begin
            failures++;
            $display("FAIL reset_recovery got lat=%0d q=%0d led=%h al=%b exp lat=%0d q=%0d led=%h al=%b",
                     lat, avg_q, led_output, alert, LATENCY, q, led, al);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_monitor_system.md
Name: temp_monitor_system

Overview:
- Multi-sensor temperature monitor.
- Averages the enabled sensor readings with a sequential restoring divider.
- Drives a thermometer-coded LED bar over the comfort window [T_MIN, T_MAX] and an out-of-range alert.
- Sits between the raw sensor bus and the front-panel display logic; one operation per start pulse.

Parameters:
- S_NR, 8, number of sensors.
- TEMP_WIDTH, 8, bits per unsigned sensor reading.
- T_MIN, 19, lowest in-range temperature.
- T_MAX, 26, highest in-range temperature; LED width = T_MAX-T_MIN+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to sample inputs; honoured only when busy=0.
- temp_value  input  S_NR*TEMP_WIDTH  packed readings; sensor k at bits [k*TEMP_WIDTH +: TEMP_WIDTH].
- temp_enable  input  S_NR  bit k=1 includes sensor k in the average.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when results update.
- avg_q  output  2*TEMP_WIDTH  average quotient (sum / count).
- avg_r  output  2*TEMP_WIDTH  remainder of sum / count.
- led_output  output  T_MAX-T_MIN+1  thermometer bar.
- alert  output  1  average outside [T_MIN, T_MAX] or no sensor enabled.

Behaviour:
- Reset (rst_n=0 at edge): all outputs 0; divider state cleared; any in-flight operation aborted with no done pulse.
- Edge k (start=1, busy=0):
  - register N = sum of enabled readings, zero-extended to 2*TEMP_WIDTH.
  - register D = popcount(temp_enable), zero-extended to 2*TEMP_WIDTH.
  - busy=1 from edge k.
- While busy=1, start is ignored and inputs may change freely.
- Edges k+1 .. k+2*TEMP_WIDTH: one restoring-division step per edge, MSB first. Each step shifts the remainder left, brings in the next N bit, and subtracts D if remainder >= D (quotient bit 1).
- Edge k+2*TEMP_WIDTH+1: avg_q, avg_r, led_output and alert are updated; done=1 for exactly that cycle; busy=0.
- Fixed latency of 17 cycles for the defaults. Outputs hold until the next done or reset.
- start may be reasserted on the cycle done is high; it is accepted at the following edge.
- Division by zero in the divider: Q = all ones, R = N.
- D=0 at the top level (no sensor enabled): avg_q=0, avg_r=0, led_output=0, alert=1. Latency is unchanged.
- LED coding with a = avg_q (truncated average, remainder ignored):
  - a <= T_MIN: led_output = 1 (bit 0 only).
  - a >= T_MAX: all ones.
  - otherwise: bits 0 .. (a-T_MIN) set, rest 0.
- alert = 1 if a < T_MIN or a > T_MAX, else 0. Endpoints T_MIN and T_MAX are in range.
- Sum width must hold S_NR*(2^TEMP_WIDTH-1) without overflow; 2*TEMP_WIDTH suffices for defaults. Elaboration-time check that S_NR <= 2^TEMP_WIDTH.

Decomposition:
- Shared package temp_monitor_pkg:
  - S_NR, TEMP_WIDTH, T_MIN, T_MAX.
  - LED_W = T_MAX-T_MIN+1.
  - DIV_W = 2*TEMP_WIDTH.
  - State enum IDLE / DIVIDE / FINISH.
- One sub-module seq_divider: DIV_W-bit restoring divider.
  - Ports: clk, rst_n, go, n, d, busy, valid, q, r.
  - Latency DIV_W cycles; handles d=0 as above.
  - Verified standalone for all n in 0..255 and d in 1..255, with q = n/d and r = n%d.
- Top contains the sum/popcount front end, the FSM and the LED/alert encoder.

Test Plan:
- All 8 enabled, every reading 22, start -> 17 cycles later done=1, avg_q=22, avg_r=0, led_output=8'h0F, alert=0.
- enable=8'h03, s0=20, s1=25 -> avg_q=22, avg_r=1, led_output=8'h0F, alert=0.
- enable=8'h01, s0 swept over 10, 19, 26, 30:
  - s0=10 -> led 8'h01, alert 1.
  - s0=19 -> led 8'h01, alert 0.
  - s0=26 -> led 8'hFF, alert 0.
  - s0=30 -> led 8'hFF, alert 1.
- enable=8'h00 -> avg_q=0, avg_r=0, led_output=8'h00, alert=1, same 17-cycle latency.
- All enabled, readings 255 -> sum 2040, avg_q=255, avg_r=0, led 8'hFF, alert 1.
- start pulsed again while busy -> ignored, exactly one done. rst_n=0 mid-operation -> next cycle all outputs 0, busy=0, no done afterwards.
